// File: rtl/psd_frame_counter.sv
// One-stage AXI-Stream register slice that tags PSD samples with BRAM byte address,
// cycle index and frame flags. Define PSD_FRAME_COUNTER_FRAME_CNT_EN for frame_count/frame_done.
module psd_frame_counter #(
  parameter int DATA_WIDTH     = 32,
  parameter int PERIOD_WIDTH   = 12,
  parameter int N_CYCLES_WIDTH = 16,
  parameter int ADDR_SHIFT     = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [PERIOD_WIDTH-1:0]            period_m1,
  input  logic [N_CYCLES_WIDTH-1:0]          n_cycles_m1,
  input  logic                               start,
  input  logic                               single_shot,
  input  logic [DATA_WIDTH-1:0]              s_axis_tdata,
  input  logic                               s_axis_tvalid,
  output logic                               s_axis_tready,
  output logic [DATA_WIDTH-1:0]              m_axis_tdata,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic                               m_axis_tlast,
  output logic [PERIOD_WIDTH+ADDR_SHIFT-1:0] addr,
  output logic [N_CYCLES_WIDTH-1:0]          cycle_index,
  output logic                               first_cycle,
  output logic                               last_cycle,
  output logic                               active,
  output logic                               busy
`ifdef PSD_FRAME_COUNTER_FRAME_CNT_EN
  ,
  output logic [31:0]                        frame_count,
  output logic                               frame_done
`endif
);

  localparam int ADDR_W = PERIOD_WIDTH + ADDR_SHIFT;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                      state_q, state_d;
  logic [PERIOD_WIDTH-1:0]     cnt;
  logic [N_CYCLES_WIDTH-1:0]   cyc;
  logic [PERIOD_WIDTH-1:0]     period_sh;
  logic [N_CYCLES_WIDTH-1:0]   n_cycles_sh;
  logic                        accept;
  logic                        cnt_wrap;
  logic                        frame_end;
  logic [ADDR_W-1:0]           cnt_addr;

  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign cnt_wrap      = (cnt == period_sh);
  assign frame_end     = busy && accept && cnt_wrap && (cyc == n_cycles_sh);
  assign cnt_addr      = ADDR_W'(cnt) << ADDR_SHIFT;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (frame_end && single_shot) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == RUN);
  end

  // Counters and config shadows; config is only sampled at start or at a frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      cyc         <= '0;
      period_sh   <= '0;
      n_cycles_sh <= '0;
    end else if (!busy) begin
      if (start) begin
        cnt         <= '0;
        cyc         <= '0;
        period_sh   <= period_m1;
        n_cycles_sh <= n_cycles_m1;
      end
    end else if (accept) begin
      if (frame_end) begin
        cnt         <= '0;
        cyc         <= '0;
        period_sh   <= period_m1;
        n_cycles_sh <= n_cycles_m1;
      end else if (cnt_wrap) begin
        cnt <= '0;
        cyc <= cyc + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Output slice: data and sidebands load together from the pre-increment counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      addr          <= '0;
      cycle_index   <= '0;
      first_cycle   <= 1'b0;
      last_cycle    <= 1'b0;
      active        <= 1'b0;
    end else if (s_axis_tready) begin
      m_axis_tvalid <= s_axis_tvalid;
      if (s_axis_tvalid) begin
        m_axis_tdata <= s_axis_tdata;
        m_axis_tlast <= frame_end;
        addr         <= busy ? cnt_addr : '0;
        cycle_index  <= busy ? cyc : '0;
        first_cycle  <= busy && (cyc == '0);
        last_cycle   <= busy && (cyc == n_cycles_sh);
        active       <= busy;
      end
    end
  end

`ifdef PSD_FRAME_COUNTER_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (frame_end && (frame_count != '1)) frame_count <= frame_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_psd_frame_counter.sv
// Scoreboard bench for psd_frame_counter: a driver pushes expected outputs from a
// frame/sample-index model, a monitor pops and compares them as the DUT presents outputs.
`timescale 1ns/1ps
module tb_psd_frame_counter;

  localparam int DW = 32;
  localparam int PW = 12;
  localparam int NW = 16;
  localparam int AS = 2;
  localparam int AW = PW + AS;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic [NW-1:0] cyc;
    logic          first;
    logic          last;
    logic          tlast;
    logic          active;
  } out_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] period_m1;
  logic [NW-1:0] n_cycles_m1;
  logic          start;
  logic          single_shot;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [AW-1:0] addr;
  logic [NW-1:0] cycle_index;
  logic          first_cycle;
  logic          last_cycle;
  logic          active;
  logic          busy;
`ifdef PSD_FRAME_COUNTER_FRAME_CNT_EN
  logic [31:0]   frame_count;
  logic          frame_done;
`endif

  psd_frame_counter #(
    .DATA_WIDTH(DW), .PERIOD_WIDTH(PW), .N_CYCLES_WIDTH(NW), .ADDR_SHIFT(AS)
  ) dut (
    .clk(clk), .rst(rst), .period_m1(period_m1), .n_cycles_m1(n_cycles_m1),
    .start(start), .single_shot(single_shot),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .addr(addr), .cycle_index(cycle_index),
    .first_cycle(first_cycle), .last_cycle(last_cycle), .active(active), .busy(busy)
`ifdef PSD_FRAME_COUNTER_FRAME_CNT_EN
    , .frame_count(frame_count), .frame_done(frame_done)
`endif
  );

  always #5 clk = ~clk;

  int n_compared = 0;
  int n_failed   = 0;

  out_t        exp_q[$];
  int unsigned fc_q[$];

  // Reference model: frame position as a flat sample index k within the frame.
  bit          m_running = 1'b0;
  bit          m_ovalid  = 1'b0;
  int unsigned m_p = 1, m_n = 1, m_k = 0, m_fc = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model advances as of the coming rising edge.
  task automatic drive(input bit v, input bit r, input bit st, input bit ss,
                       input int unsigned pm, input int unsigned nm, input bit rs);
    out_t e;
    bit   exp_ready;
    bit   acc;
    @(negedge clk);
    rst           = rs;
    s_axis_tvalid = v;
    s_axis_tdata  = $urandom;
    m_axis_tready = r;
    start         = st;
    single_shot   = ss;
    period_m1     = pm[PW-1:0];
    n_cycles_m1   = nm[NW-1:0];
    #1;
    if (rs) begin
      m_running = 1'b0;
      m_ovalid  = 1'b0;
      m_k       = 0;
      m_fc      = 0;
      return;
    end
    exp_ready = !m_ovalid || r;
    check("s_axis_tready", 128'(s_axis_tready), 128'(exp_ready));
    acc = v && exp_ready;
    if (exp_ready) m_ovalid = v;
    e = '0;
    e.data = s_axis_tdata;
    if (!m_running) begin
      if (acc) begin
        exp_q.push_back(e);
        fc_q.push_back(m_fc);
      end
      if (st) begin
        m_running = 1'b1;
        m_p = pm + 1;
        m_n = nm + 1;
        m_k = 0;
      end
    end else if (acc) begin
      e.addr   = AW'((m_k % m_p) << AS);
      e.cyc    = NW'(m_k / m_p);
      e.first  = (m_k / m_p) == 0;
      e.last   = (m_k / m_p) == m_n - 1;
      e.tlast  = (m_k == m_p * m_n - 1);
      e.active = 1'b1;
      m_k++;
      if (e.tlast) begin
        m_fc++;
        m_k = 0;
        if (ss) m_running = 1'b0;
        else begin
          m_p = pm + 1;
          m_n = nm + 1;
        end
      end
      exp_q.push_back(e);
      fc_q.push_back(m_fc);
    end
  endtask

  // Monitor: samples 2 ns after each rising edge.
  initial begin
    bit   pv;
    bit   hs;
    out_t cur;
    out_t act;
`ifdef PSD_FRAME_COUNTER_FRAME_CNT_EN
    int unsigned exp_fc;
`endif
    pv  = 1'b0;
    cur = '0;
    forever begin
      @(posedge clk);
      #2;
      act = {m_axis_tdata, addr, cycle_index, first_cycle, last_cycle, m_axis_tlast, active};
      if (rst) begin
        check("reset_outputs", 128'({m_axis_tvalid, busy, act}), 128'(0));
        pv = 1'b0;
      end else begin
        hs = pv && m_axis_tready;
        check("busy", 128'(busy), 128'(m_running));
        if (pv && !hs) begin
          check("hold", 128'({m_axis_tvalid, act}), 128'({1'b1, cur}));
        end else if (m_axis_tvalid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", 128'(act), 128'(0));
          end else begin
            cur = exp_q.pop_front();
            check("output", 128'(act), 128'(cur));
`ifdef PSD_FRAME_COUNTER_FRAME_CNT_EN
            exp_fc = fc_q.pop_front();
            check("frame_count", 128'(frame_count), 128'(exp_fc));
            check("frame_done", 128'(frame_done), 128'(cur.tlast));
`else
            fc_q.delete(0);
`endif
          end
        end else begin
          check("missing_output", 128'(exp_q.size()), 128'(0));
        end
        pv = m_axis_tvalid;
      end
    end
  end

  initial begin
    bit [3:0] pat;
    rst = 1'b1; start = 1'b0; single_shot = 1'b0; period_m1 = '0; n_cycles_m1 = '0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; m_axis_tready = 1'b0;
    repeat (3) drive(1, 1, 0, 0, 0, 0, 1);

    // Single shot 4x2 with a sample coinciding with start, then pass-through samples.
    drive(1, 1, 1, 1, 3, 1, 0);
    repeat (12) drive(1, 1, 0, 1, 3, 1, 0);

    // Continuous 2x3, then close with a single-shot frame end.
    drive(0, 1, 1, 0, 1, 2, 0);
    repeat (12) drive(1, 1, 0, 0, 1, 2, 0);
    for (int i = 0; i < 64 && m_running; i++) drive(1, 1, 0, 1, 1, 2, 0);

    // Backpressure with ready pattern 1,0,0,1.
    pat = 4'b1001;
    drive(0, 1, 1, 0, 3, 1, 0);
    for (int i = 0; i < 32; i++) drive(1, pat[i % 4], 0, 0, 3, 1, 0);
    drive(0, 1, 0, 0, 0, 0, 1);

    // Config change mid-frame: period 4 until the frame end, then period 2.
    drive(0, 1, 1, 0, 3, 1, 0);
    repeat (2) drive(1, 1, 0, 0, 3, 1, 0);
    repeat (16) drive(1, 1, 0, 0, 1, 1, 0);
    drive(0, 1, 0, 0, 0, 0, 1);

    // Degenerate 1x1, continuous, random downstream ready.
    drive(0, 1, 1, 0, 0, 0, 0);
    repeat (16) drive(1, 1'($urandom_range(0, 1)), 0, 0, 0, 0, 0);

    // Reset on sample 3 of a frame, then restart.
    drive(1, 1, 0, 0, 0, 0, 1);
    drive(0, 1, 1, 0, 3, 1, 0);
    repeat (2) drive(1, 1, 0, 0, 3, 1, 0);
    drive(1, 1, 0, 0, 3, 1, 1);
    drive(1, 1, 1, 0, 3, 1, 0);
    repeat (10) drive(1, 1, 0, 0, 3, 1, 0);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
            $urandom_range(0, 4), $urandom_range(0, 3),
            1'($urandom_range(0, 499) == 0));
    end

    for (int i = 0; i < 20; i++) drive(0, 1, 0, 0, 0, 0, 0);
    check("drained", 128'(exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
